gsm_mul_arbiter: RTL and testbench
==================================

# gsm_mul_arbiter

Round-robin arbiter and sequencer that shares one 16x16 signed multiplier among `NUM_REQ` requesters in the GSM codec datapath. Each request carries a mode that selects one of the GSM fixed-point multiply variants: raw product, `mult`, `mult_r` or `L_mult`. Saturation and rounding are applied in this block. One result per cycle is returned through a registered valid/ready output tagged with the requester ID. The block sits between the LPC/LTP filter stages and the single shared multiplier resource.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ID_W`, 2: requester ID width, equal to clog2(`NUM_REQ`).
- `ap_clk` in 1: clock; all state updates on the rising edge.
- `ap_rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in `NUM_REQ`: per-requester request valid.
- `req_ready` out `NUM_REQ`: per-requester accept; one-hot or zero.
- `req_a` in `NUM_REQ`*16: signed operand A, slice i belongs to requester i.
- `req_b` in `NUM_REQ`*16: signed operand B.
- `req_mode` in `NUM_REQ`*2: 0 RAW, 1 MULT, 2 MULT_R, 3 L_MULT.
- `rsp_valid` out 1: result valid.
- `rsp_ready` in 1: downstream accepts the result.
- `rsp_id` out `ID_W`: requester index of the result.
- `rsp_data` out 32: result.
- `sat_clr` in 1: synchronous clear of `sat_cnt`.
- `sat_cnt` out 16: count of saturation events.

## Operation
- `can_accept` = !`rsp_valid` || `rsp_ready`.
- Grant goes to the first i with `req_valid[i]`, searching from `rr_ptr` upward modulo `NUM_REQ`.
- `req_ready[i]` = `can_accept` && grant==i. It is combinational and may depend on `req_valid`.
- A transfer on requester i occurs when `req_valid[i]` && `req_ready[i]`.
- On a transfer:
  - The output register loads the result, `rsp_id`=i and `rsp_valid`=1.
  - `rr_ptr` becomes (i+1) mod `NUM_REQ`.
- With no transfer, `rr_ptr` holds.
- If `rsp_valid` && `rsp_ready` with no new transfer, `rsp_valid` goes to 0. `rsp_data` and `rsp_id` hold their values.
- Product: p = signed(a)*signed(b), 32-bit. "Both-min" means a==b==-32768.
- RAW: p.
- MULT: both-min gives 32767, otherwise p>>>15. The result is sign-extended to 32 bits.
- MULT_R: both-min gives 32767, otherwise (p+16384)>>>15, sign-extended.
- L_MULT: both-min gives 0x7FFFFFFF, otherwise p<<1.
- A both-min operand pair in modes 1–3 is a saturation event.
- `sat_cnt` increments on each accepted saturation event and sticks at 0xFFFF.
- `sat_clr` has priority over an increment in the same cycle.

## Timing
- Reset values: `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `rr_ptr`=0, `sat_cnt`=0. `req_ready`=0 while `ap_rst_n` is low.
- Reset asserted mid-operation clears the held result immediately; that result is lost.
- Latency: a request accepted at edge N produces `rsp_valid` high after edge N.
- Throughput: one result per cycle while `rsp_ready` is held 1. Drain and accept in the same cycle is allowed.
- Backpressure: while `rsp_valid`=1 and `rsp_ready`=0, every `req_ready`=0 and all output registers hold.
- Fairness: a requester holding `req_valid` is granted within `NUM_REQ` accepting cycles.
- Requesters must keep operands and mode stable while valid is high and not yet accepted.
- Only one requester valid: that requester is granted regardless of `rr_ptr`.

## Structure
- Package `gsm_mul_pkg` holds:
  - the mode enum (RAW, MULT, MULT_R, L_MULT);
  - the constants MIN16 = -32768, MAX16 = 32767, MAX32 = 0x7FFFFFFF, ROUND15 = 16384.
- Sub-module `gsm_mul_rr_grant`: combinational round-robin priority encoder. Inputs are the valid vector and `rr_ptr`; outputs are the grant index and an any-grant flag.
- The multiply itself is an inferred 16x16 signed multiply in the top module, mapping to a single DSP.

## Test plan
- Reset state:
  - Hold `ap_rst_n`=0 → all outputs 0.
  - Release, then req0 RAW a=3, b=-5 → `rsp_data`=0xFFFFFFF1, `rsp_id`=0 one edge later.
- Mode arithmetic:
  - a=b=0x4000: MULT → 0x00002000; MULT_R → 0x00002000; L_MULT → 0x20000000.
  - a=b=-32768: MULT → 32767, L_MULT → 0x7FFFFFFF, `sat_cnt`=2.
- Round-robin:
  - All 4 requesters valid continuously, `rsp_ready`=1 → grant order 0,1,2,3,0 and one result per cycle.
  - Drop req1 → order 0,2,3,0.
- Backpressure:
  - `rsp_ready`=0 for 5 cycles with requests pending → `req_ready`=0, `rsp_data` stable.
  - Release → pending requests drain with no loss or duplication.
- Asynchronous reset mid-stream:
  - Assert `ap_rst_n` low between edges while `rsp_valid`=1 → `rsp_valid`=0 immediately, `rr_ptr` restarts at 0.
- Counter boundaries:
  - Force `sat_cnt` to 0xFFFF, send a saturation event → value stays 0xFFFF.
  - Send `sat_clr` together with an event → value 0.

Source files
------------

// File: rtl/gsm_mul_pkg.sv
// Shared types and constants for the GSM multiplier arbiter.
// Mode encoding and fixed-point limits used by the mul/round/sat logic.
package gsm_mul_pkg;

  typedef enum logic [1:0] {
    MODE_RAW    = 2'd0,
    MODE_MULT   = 2'd1,
    MODE_MULT_R = 2'd2,
    MODE_L_MULT = 2'd3
  } mode_e;

  localparam logic signed [15:0] MIN16   = 16'sh8000;
  localparam logic signed [15:0] MAX16   = 16'sh7FFF;
  localparam logic signed [31:0] MAX32   = 32'sh7FFFFFFF;
  localparam logic signed [31:0] ROUND15 = 32'sd16384;

  function automatic logic both_min16(
    input logic signed [15:0] a,
    input logic signed [15:0] b
  );
    return (a == MIN16) && (b == MIN16);
  endfunction

endpackage

// File: rtl/gsm_mul_rr_grant.sv
// Combinational round-robin priority encoder.
// Searches upward from ptr, wrapping modulo NUM_REQ.
module gsm_mul_rr_grant
  import gsm_mul_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    gnt,
  output logic               any
);

  localparam logic [ID_W:0] NR = (ID_W+1)'(NUM_REQ);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;

  // Walk from the farthest slot back so the nearest valid wins.
  always_comb begin
    gnt = '0;
    any = 1'b0;
    sum = '0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (ID_W+1)'(k);
      if (sum >= NR) sum = sum - NR;
      idx = sum[ID_W-1:0];
      if (valid[idx]) begin
        gnt = idx;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gsm_mul_arbiter.sv
// Round-robin sharing of one 16x16 signed multiplier among requesters,
// with GSM mult/mult_r/L_mult rounding and saturation on the result.
module gsm_mul_arbiter
  import gsm_mul_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*16-1:0]  req_a,
  input  logic [NUM_REQ*16-1:0]  req_b,
  input  logic [NUM_REQ*2-1:0]   req_mode,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [31:0]            rsp_data,
  input  logic                   sat_clr,
  output logic [15:0]            sat_cnt
);

  localparam logic [ID_W-1:0] LAST = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    gnt;
  logic               any_gnt;
  logic               can_accept;
  logic               xfer;
  logic signed [15:0] op_a;
  logic signed [15:0] op_b;
  mode_e              mode;
  logic signed [31:0] prod;
  logic signed [31:0] prod_r;
  logic signed [31:0] result;
  logic               both_min;
  logic               sat_evt;

  gsm_mul_rr_grant #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_grant (
    .valid(req_valid),
    .ptr  (rr_ptr),
    .gnt  (gnt),
    .any  (any_gnt)
  );

  assign can_accept = !rsp_valid || rsp_ready;
  assign xfer = ap_rst_n && can_accept && any_gnt;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[gnt] = 1'b1;
  end

  always_comb begin
    op_a = '0;
    op_b = '0;
    mode = MODE_RAW;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt == ID_W'(i)) begin
        op_a = req_a[i*16 +: 16];
        op_b = req_b[i*16 +: 16];
        mode = mode_e'(req_mode[i*2 +: 2]);
      end
    end
  end

  assign prod     = op_a * op_b;
  assign prod_r   = prod + ROUND15;
  assign both_min = both_min16(op_a, op_b);

  always_comb begin
    result = prod;
    unique case (mode)
      MODE_RAW:    result = prod;
      MODE_MULT:   result = both_min ? 32'(MAX16) : (prod >>> 15);
      MODE_MULT_R: result = both_min ? 32'(MAX16) : (prod_r >>> 15);
      MODE_L_MULT: result = both_min ? MAX32 : (prod <<< 1);
      default:     result = prod;
    endcase
  end

  assign sat_evt = xfer && both_min && (mode != MODE_RAW);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rr_ptr    <= '0;
    end else if (xfer) begin
      rsp_valid <= 1'b1;
      rsp_id    <= gnt;
      rsp_data  <= result;
      rr_ptr    <= (gnt == LAST) ? '0 : gnt + ID_W'(1);
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      sat_cnt <= '0;
    end else if (sat_clr) begin
      sat_cnt <= '0;
    end else if (sat_evt && sat_cnt != 16'hFFFF) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_gsm_mul_arbiter.sv
// Scoreboard bench for gsm_mul_arbiter: requester agents, a grant/result
// model checked every cycle, and directed scenario tasks.
module tb_gsm_mul_arbiter;

  localparam int N = 4;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_ready;
  logic [N*16-1:0] req_a = '0;
  logic [N*16-1:0] req_b = '0;
  logic [N*2-1:0]  req_mode = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [1:0]    rsp_id;
  logic [31:0]   rsp_data;
  logic          sat_clr = 1'b0;
  logic [15:0]   sat_cnt;

  int total = 0;
  int bad = 0;

  gsm_mul_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_mode (req_mode),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_data (rsp_data),
    .sat_clr  (sat_clr),
    .sat_cnt  (sat_cnt)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
  } exp_t;

  logic [15:0] op_a[N];
  logic [15:0] op_b[N];
  logic [1:0]  op_m[N];
  int          rem[N];
  bit          acc[N];
  bit          rnd_ops = 1'b0;

  exp_t sb[$];
  int   gq[$];
  int   tq[$];
  int   cyc = 0;
  int   mptr = 0;
  bit   mrv = 1'b0;
  bit   new_out = 1'b0;
  int   pushes = 0;
  int   pops = 0;

  initial begin
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
      op_m[i] = '0;
      rem[i] = 0;
      acc[i] = 1'b0;
    end
  end

  function automatic logic [31:0] ref_result(
    input logic [15:0] a,
    input logic [15:0] b,
    input logic [1:0]  m
  );
    longint p;
    longint q;
    bit bm;
    p = longint'($signed(a)) * longint'($signed(b));
    bm = (a == 16'h8000) && (b == 16'h8000);
    q = p;
    case (m)
      2'd1: q = bm ? 64'sd32767 : (p >>> 15);
      2'd2: q = bm ? 64'sd32767 : ((p + 64'sd16384) >>> 15);
      2'd3: q = bm ? 64'sh7FFFFFFF : (p * 2);
      default: q = p;
    endcase
    return q[31:0];
  endfunction

  function automatic void drive();
    for (int i = 0; i < N; i++) begin
      req_a[i*16 +: 16] = op_a[i];
      req_b[i*16 +: 16] = op_b[i];
      req_mode[i*2 +: 2] = op_m[i];
      req_valid[i] = (rem[i] > 0);
    end
  endfunction

  function automatic void new_ops(input int i);
    op_a[i] = 16'($urandom);
    op_b[i] = 16'($urandom);
    op_m[i] = 2'($urandom_range(0, 3));
    if ($urandom_range(0, 7) == 0) begin
      op_a[i] = 16'h8000;
      op_b[i] = 16'h8000;
    end
  endfunction

  // Requester agents: retire accepted ops just after the edge.
  initial begin
    forever begin
      @(posedge ap_clk);
      #1;
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          acc[i] = 1'b0;
          if (rem[i] > 0) rem[i]--;
          if (rnd_ops) new_ops(i);
        end
      end
      drive();
    end
  end

  // Monitor: model grant/valid, push expectations, pop and compare results.
  initial begin
    forever begin
      @(negedge ap_clk);
      if (!ap_rst_n) begin
        mptr = 0;
        mrv = 1'b0;
        new_out = 1'b0;
        sb.delete();
        for (int i = 0; i < N; i++) acc[i] = 1'b0;
      end else begin
        int g;
        logic [N-1:0] exp_rdy;
        exp_t e;
        total++;
        if (rsp_valid !== mrv) begin
          bad++;
          $display("FAIL rsp_valid got=%b want=%b t=%0t", rsp_valid, mrv, $time);
        end
        if (new_out) begin
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty got=%h want=entry", rsp_data);
          end else begin
            e = sb.pop_front();
            pops++;
            if (rsp_id !== e.id || rsp_data !== e.data) begin
              bad++;
              $display("FAIL result got=%0d/%h want=%0d/%h t=%0t",
                       rsp_id, rsp_data, e.id, e.data, $time);
            end
          end
        end
        g = -1;
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (mptr + k) % N;
          if (g < 0 && req_valid[idx]) g = idx;
        end
        exp_rdy = '0;
        if ((!mrv || rsp_ready) && g >= 0) exp_rdy[g] = 1'b1;
        total++;
        if (req_ready !== exp_rdy) begin
          bad++;
          $display("FAIL req_ready got=%b want=%b t=%0t", req_ready, exp_rdy, $time);
        end
        if (exp_rdy != '0) begin
          acc[g] = 1'b1;
          e.id = 2'(g);
          e.data = ref_result(req_a[g*16 +: 16], req_b[g*16 +: 16], req_mode[g*2 +: 2]);
          sb.push_back(e);
          pushes++;
          gq.push_back(g);
          tq.push_back(cyc);
          mptr = (g + 1) % N;
          mrv = 1'b1;
          new_out = 1'b1;
        end else begin
          new_out = 1'b0;
          if (rsp_ready) mrv = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(posedge ap_clk);
    #2;
    for (int i = 0; i < N; i++) rem[i] = 0;
    drive();
    ap_rst_n = 1'b0;
    @(posedge ap_clk);
    #2;
    ap_rst_n = 1'b1;
    gq.delete();
    tq.delete();
  endtask

  task automatic send(input int id, input logic [15:0] a,
                      input logic [15:0] b, input logic [1:0] m);
    bit done;
    @(posedge ap_clk);
    #2;
    op_a[id] = a;
    op_b[id] = b;
    op_m[id] = m;
    rem[id] = 1;
    drive();
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge ap_clk);
      if (rem[id] == 0) done = 1'b1;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL send_timeout got=pending want=accepted id=%0d", id);
    end
  endtask

  task automatic check32(input string nm, input logic [31:0] got,
                         input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic test_reset();
    rnd_ops = 1'b0;
    op_a[0] = 16'd3;
    op_b[0] = 16'hFFFB;
    op_m[0] = 2'd0;
    rem[0] = 1;
    drive();
    repeat (3) @(negedge ap_clk);
    check32("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check32("rst_rsp_data", rsp_data, 32'd0);
    check32("rst_rsp_id", 32'(rsp_id), 32'd0);
    check32("rst_req_ready", 32'(req_ready), 32'd0);
    check32("rst_sat_cnt", 32'(sat_cnt), 32'd0);
    @(posedge ap_clk);
    #2;
    ap_rst_n = 1'b1;
    for (int k = 0; k < 10 && rem[0] != 0; k++) @(negedge ap_clk);
    check32("first_raw_data", rsp_data, 32'hFFFFFFF1);
    check32("first_raw_id", 32'(rsp_id), 32'd0);
  endtask

  task automatic test_mode_arith();
    rnd_ops = 1'b0;
    rsp_ready = 1'b1;
    send(0, 16'h4000, 16'h4000, 2'd1);
    check32("mult_4000", rsp_data, 32'h00002000);
    send(1, 16'h4000, 16'h4000, 2'd2);
    check32("mult_r_4000", rsp_data, 32'h00002000);
    send(2, 16'h4000, 16'h4000, 2'd3);
    check32("l_mult_4000", rsp_data, 32'h20000000);
    send(3, 16'hFFFF, 16'h0001, 2'd2);
    check32("mult_r_neg", rsp_data, 32'h00000000);
    check32("sat_before_min", 32'(sat_cnt), 32'd0);
    send(1, 16'h8000, 16'h8000, 2'd1);
    check32("mult_min", rsp_data, 32'h00007FFF);
    send(3, 16'h8000, 16'h8000, 2'd3);
    check32("l_mult_min", rsp_data, 32'h7FFFFFFF);
    check32("sat_cnt_two", 32'(sat_cnt), 32'd2);
    send(0, 16'h8000, 16'h8000, 2'd0);
    check32("raw_min", rsp_data, 32'h40000000);
    check32("sat_raw_none", 32'(sat_cnt), 32'd2);
  endtask

  task automatic wait_grants(input int n);
    for (int k = 0; k < 40 && gq.size() < n; k++) @(negedge ap_clk);
    total++;
    if (gq.size() < n) begin
      bad++;
      $display("FAIL grant_count got=%0d want=%0d", gq.size(), n);
    end
  endtask

  task automatic test_round_robin();
    int want_all[5] = '{0, 1, 2, 3, 0};
    int want_drop[4] = '{0, 2, 3, 0};
    do_reset();
    rnd_ops = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) rem[i] = 6;
    drive();
    wait_grants(5);
    for (int k = 0; k < 5 && k < gq.size(); k++)
      check32("rr_all_order", 32'(gq[k]), 32'(want_all[k]));
    if (tq.size() >= 5) check32("rr_per_cycle", 32'(tq[4] - tq[0]), 32'd4);
    do_reset();
    rem[0] = 6;
    rem[2] = 6;
    rem[3] = 6;
    drive();
    wait_grants(4);
    for (int k = 0; k < 4 && k < gq.size(); k++)
      check32("rr_drop_order", 32'(gq[k]), 32'(want_drop[k]));
  endtask

  task automatic test_backpressure();
    int p0;
    int q0;
    logic [31:0] held;
    bit busy;
    do_reset();
    rnd_ops = 1'b1;
    rsp_ready = 1'b0;
    p0 = pushes;
    q0 = pops;
    for (int i = 0; i < N; i++) rem[i] = 2;
    drive();
    for (int k = 0; k < 20 && !rsp_valid; k++) @(negedge ap_clk);
    check32("bp_valid", 32'(rsp_valid), 32'd1);
    held = rsp_data;
    for (int k = 0; k < 5; k++) begin
      @(negedge ap_clk);
      check32("bp_req_ready", 32'(req_ready), 32'd0);
      check32("bp_data_hold", rsp_data, held);
    end
    @(posedge ap_clk);
    #2;
    rsp_ready = 1'b1;
    busy = 1'b1;
    for (int k = 0; k < 40 && busy; k++) begin
      @(negedge ap_clk);
      busy = (pops - q0 < 8) || (sb.size() != 0);
    end
    @(negedge ap_clk);
    check32("bp_pushes", 32'(pushes - p0), 32'd8);
    check32("bp_pops", 32'(pops - q0), 32'd8);
    check32("bp_drained", 32'(rsp_valid), 32'd0);
  endtask

  task automatic test_async_reset();
    do_reset();
    rnd_ops = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) rem[i] = 8;
    drive();
    wait_grants(2);
    @(posedge ap_clk);
    #2;
    check32("ar_pre_valid", 32'(rsp_valid), 32'd1);
    ap_rst_n = 1'b0;
    #1;
    check32("ar_valid", 32'(rsp_valid), 32'd0);
    check32("ar_data", rsp_data, 32'd0);
    check32("ar_id", 32'(rsp_id), 32'd0);
    check32("ar_ready", 32'(req_ready), 32'd0);
    gq.delete();
    @(posedge ap_clk);
    #2;
    ap_rst_n = 1'b1;
    wait_grants(1);
    if (gq.size() > 0) check32("ar_ptr_restart", 32'(gq[0]), 32'd0);
    do_reset();
  endtask

  task automatic test_sat_counter();
    rnd_ops = 1'b0;
    rsp_ready = 1'b1;
    @(posedge ap_clk);
    #2;
    force dut.sat_cnt = 16'hFFFF;
    #1;
    release dut.sat_cnt;
    send(1, 16'h8000, 16'h8000, 2'd2);
    check32("mult_r_min", rsp_data, 32'h00007FFF);
    check32("sat_sticky", 32'(sat_cnt), 32'hFFFF);
    sat_clr = 1'b1;
    send(2, 16'h8000, 16'h8000, 2'd3);
    check32("sat_clr_prio", 32'(sat_cnt), 32'd0);
    sat_clr = 1'b0;
    send(0, 16'h8000, 16'h8000, 2'd1);
    check32("sat_after_clr", 32'(sat_cnt), 32'd1);
  endtask

  initial begin
    test_reset();
    test_mode_arith();
    test_round_robin();
    test_backpressure();
    test_async_reset();
    test_sat_counter();
    repeat (2) @(negedge ap_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
